// File: rtl/regfile_scoreboard.sv
// Multi-port register file with same-cycle write bypass, a per-register pending-producer
// scoreboard and a ready/valid dump engine that streams every register out in index order.
module regfile_scoreboard #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int NUM_REGS       = 32,
    parameter int NUM_RD_PORTS   = 2,
    parameter int NUM_WR_PORTS   = 2,
    localparam int ADDR_W        = $clog2(NUM_REGS)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0]         rd_addr,
    output logic [NUM_RD_PORTS*BUS_DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]                rd_busy,
    input  logic [NUM_WR_PORTS-1:0]                wr_en,
    input  logic [NUM_WR_PORTS*ADDR_W-1:0]         wr_addr,
    input  logic [NUM_WR_PORTS*BUS_DATA_WIDTH-1:0] wr_data,
    input  logic                                   issue_en,
    input  logic [ADDR_W-1:0]                      issue_rd,
    input  logic                                   dump_req,
    output logic                                   dump_valid,
    input  logic                                   dump_ready,
    output logic [ADDR_W-1:0]                      dump_idx,
    output logic [BUS_DATA_WIDTH-1:0]              dump_data,
    output logic                                   dump_done
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } dump_state_t;

    logic [BUS_DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]       busy;
    dump_state_t               state, state_next;
    logic [ADDR_W-1:0]         idx, idx_next;

    // NOTE: the register array is reset because a mid-dump reset must leave every register reading 0;
    // inside each loop the later non-blocking assignment to the same entry wins, giving
    // highest-numbered-port priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] != '0)
                    regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            end
        end
    end

    // A write retires the producer; an issue in the same cycle is newer, so it is applied last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (wr_en[w]) busy[wr_addr[w*ADDR_W +: ADDR_W]] <= 1'b0;
            end
            if (issue_en && issue_rd != '0) busy[issue_rd] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0]         addr;
        logic [BUS_DATA_WIDTH-1:0] data;
        logic                      hit;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        // NOTE: every variable gets a default before the loop so no latch is inferred.
        always_comb begin
            data = regs[addr];
            hit  = 1'b0;
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == addr) begin
                    data = wr_data[w*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                    hit  = 1'b1;
                end
            end
        end

        // Reads are forced to zero while reset is held so a bypassed write cannot leak through.
        assign rd_data[p*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = (reset && addr != '0) ? data : '0;
        assign rd_busy[p] = reset && (addr != '0) && busy[addr] && !hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    state_next = STREAM;
                    idx_next   = '0;
                end
            end
            STREAM: begin
                if (dump_ready) begin
                    if (idx == ADDR_W'(NUM_REGS - 1)) state_next = DONE;
                    else                              idx_next   = idx + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                idx_next   = '0;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign dump_valid = (state == STREAM);
    assign dump_done  = (state == DONE);
    assign dump_idx   = idx;
    assign dump_data  = regs[idx];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a behavioural register/busy model feeds expectation
// queues for reads and dump beats, which are popped and compared as the DUT produces output.
module tb_regfile_scoreboard;

    localparam int W  = 64;
    localparam int NR = 32;
    localparam int AW = 5;

    typedef struct {
        int          port;
        logic [W-1:0] data;
        logic        busy;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] idx;
        logic [W-1:0]  data;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [2*AW-1:0] rd_addr;
    logic [2*W-1:0]  rd_data;
    logic [1:0]      rd_busy;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*W-1:0]  wr_data;
    logic            issue_en;
    logic [AW-1:0]   issue_rd;
    logic            dump_req;
    logic            dump_valid;
    logic            dump_ready;
    logic [AW-1:0]   dump_idx;
    logic [W-1:0]    dump_data;
    logic            dump_done;

    regfile_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .dump_req   (dump_req),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    rd_exp_t rd_q[$];
    beat_t   dump_q[$];
    logic [W-1:0] mdl [NR];
    logic [NR-1:0] mdl_busy;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en[p]         = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*W +: W]   = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic expect_rd(input int p, input logic [W-1:0] d, input logic b);
        rd_q.push_back('{port: p, data: d, busy: b});
    endtask

    // Compares all pending read expectations against the combinational outputs mid-cycle.
    task automatic sample();
        rd_exp_t e;
        #2;
        while (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            check($sformatf("rd_data[%0d]", e.port), rd_data[e.port*W +: W], e.data);
            check($sformatf("rd_busy[%0d]", e.port), 64'(rd_busy[e.port]), 64'(e.busy));
        end
    endtask

    // Advances the model with the inputs about to be sampled, then moves to just after the edge.
    task automatic step();
        logic [AW-1:0] a;
        if (!reset) begin
            for (int r = 0; r < NR; r++) mdl[r] = '0;
            mdl_busy = '0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                a = wr_addr[w*AW +: AW];
                if (wr_en[w] && a != 0) begin
                    mdl[a]      = wr_data[w*W +: W];
                    mdl_busy[a] = 1'b0;
                end
            end
            if (issue_en && issue_rd != 0) mdl_busy[issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_en    = '0;
        issue_en = 1'b0;
        dump_req = 1'b0;
    endtask

    task automatic run_dump(input bit toggle, input bit poke_req);
        int done_cnt = 0;
        bit prev_hold = 0;
        logic [AW-1:0] prev_idx = '0;
        logic [W-1:0]  prev_data = '0;
        beat_t b;
        for (int i = 0; i < NR; i++) dump_q.push_back('{idx: AW'(i), data: mdl[i]});
        dump_req = 1'b1;
        step();
        for (int cyc = 0; cyc < 300; cyc++) begin
            dump_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            dump_req   = poke_req && (cyc == 5);
            #2;
            if (prev_hold) begin
                check("dump_hold_valid", 64'(dump_valid), 64'd1);
                check("dump_hold_idx", 64'(dump_idx), 64'(prev_idx));
                check("dump_hold_data", dump_data, prev_data);
            end
            if (dump_valid && dump_ready) begin
                if (dump_q.size() == 0) begin
                    check("dump_extra_beat", 64'(dump_idx), 64'hFFFF);
                end else begin
                    b = dump_q.pop_front();
                    check("dump_idx", 64'(dump_idx), 64'(b.idx));
                    check("dump_data", dump_data, b.data);
                end
            end
            prev_hold = dump_valid && !dump_ready;
            prev_idx  = dump_idx;
            prev_data = dump_data;
            if (dump_done) begin
                check("dump_done_valid_low", 64'(dump_valid), 64'd0);
                done_cnt++;
                break;
            end
            step();
        end
        check("dump_done_pulses", 64'(done_cnt), 64'd1);
        check("dump_beats_left", 64'(dump_q.size()), 64'd0);
        dump_q.delete();
        step();
        #2;
        check("dump_done_one_cycle", 64'(dump_done), 64'd0);
        check("dump_idle_valid", 64'(dump_valid), 64'd0);
        step();
        #2;
        check("dump_req_not_queued", 64'(dump_valid), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] a0, a1;
        logic [W-1:0]  d0, d1;

        reset = 1'b0;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_rd = '0; dump_req = 1'b0; dump_ready = 1'b0;
        for (int r = 0; r < NR; r++) mdl[r] = '0;
        mdl_busy = '0;

        // Reset holds everything at zero, even a bypassed write and an issue.
        #1;
        set_wr(0, 5, 64'hFF); set_rd(0, 5); issue_en = 1'b1; issue_rd = 5;
        expect_rd(0, 64'h0, 1'b0);
        sample();
        check("rst_dump_valid", 64'(dump_valid), 64'd0);
        check("rst_dump_done", 64'(dump_done), 64'd0);
        check("rst_dump_idx", 64'(dump_idx), 64'd0);
        step();
        set_rd(0, 5); expect_rd(0, 64'h0, 1'b0);
        sample();
        reset = 1'b1;

        // First edge after release accepts a write.
        set_wr(0, 9, 64'h99);
        step();
        set_rd(0, 9); expect_rd(0, 64'h99, 1'b0);
        sample();

        // Same-address writes on both ports: port 1 wins, both bypassed and committed.
        set_wr(0, 5, 64'hA); set_wr(1, 5, 64'hB); set_rd(0, 5);
        expect_rd(0, 64'hB, 1'b0);
        sample();
        step();
        set_rd(0, 5); expect_rd(0, 64'hB, 1'b0);
        sample();

        // Bypass of r7 and writes to r0 ignored.
        set_wr(0, 7, 64'h1234); set_rd(0, 7); set_rd(1, 0);
        expect_rd(0, 64'h1234, 1'b0);
        sample();
        step();
        set_wr(1, 0, 64'hFF); set_rd(1, 0);
        expect_rd(1, 64'h0, 1'b0); expect_rd(0, 64'h1234, 1'b0);
        sample();
        step();
        expect_rd(1, 64'h0, 1'b0);
        sample();

        // Scoreboard: issue, retire, and issue racing a write.
        issue_en = 1'b1; issue_rd = 3; set_rd(0, 3);
        expect_rd(0, 64'h0, 1'b0);
        sample();
        step();
        expect_rd(0, 64'h0, 1'b1);
        sample();
        set_wr(0, 3, 64'h33);
        expect_rd(0, 64'h33, 1'b0);
        sample();
        step();
        expect_rd(0, 64'h33, 1'b0);
        sample();
        issue_en = 1'b1; issue_rd = 3; set_wr(1, 3, 64'h44);
        expect_rd(0, 64'h44, 1'b0);
        sample();
        step();
        expect_rd(0, 64'h44, 1'b1);
        sample();
        issue_en = 1'b1; issue_rd = 0; set_rd(1, 0);
        step();
        expect_rd(1, 64'h0, 1'b0);
        sample();

        // Random dual-port traffic against the model.
        for (int i = 0; i < 8; i++) begin
            a0 = AW'($urandom_range(1, NR - 1)); a1 = AW'($urandom_range(1, NR - 1));
            d0 = {$urandom, $urandom};           d1 = {$urandom, $urandom};
            set_wr(0, a0, d0); set_wr(1, a1, d1);
            step();
            a0 = AW'($urandom_range(0, NR - 1)); a1 = AW'($urandom_range(0, NR - 1));
            set_rd(0, a0); set_rd(1, a1);
            expect_rd(0, mdl[a0], mdl_busy[a0]); expect_rd(1, mdl[a1], mdl_busy[a1]);
            sample();
        end

        // Preload r1..r31 with their index, then dump with ready toggling and a stray request.
        for (int i = 1; i < NR; i += 2) begin
            set_wr(0, AW'(i), 64'(i));
            if (i + 1 < NR) set_wr(1, AW'(i + 1), 64'(i + 1));
            step();
        end
        for (int i = 0; i < NR; i++) check($sformatf("preload_model_r%0d", i), mdl[i], 64'(i));
        run_dump(1'b1, 1'b1);

        // Reset in the middle of a dump aborts with no done pulse and clears everything.
        dump_ready = 1'b1;
        dump_req = 1'b1;
        step();
        for (int c = 0; c < 60 && dump_idx != 10; c++) step();
        check("abort_at_idx10", 64'(dump_idx), 64'd10);
        reset = 1'b0;
        set_wr(0, 5, 64'h77); set_rd(0, 5); set_rd(1, 31);
        expect_rd(0, 64'h0, 1'b0); expect_rd(1, 64'h0, 1'b0);
        sample();
        check("abort_valid_low", 64'(dump_valid), 64'd0);
        check("abort_idx_zero", 64'(dump_idx), 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("abort_no_done", 64'(dump_done), 64'd0);
        end
        reset = 1'b1;
        set_rd(0, 3); set_rd(1, 31);
        expect_rd(0, 64'h0, 1'b0); expect_rd(1, 64'h0, 1'b0);
        sample();
        step();
        check("post_abort_idle", 64'(dump_valid), 64'd0);
        run_dump(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
